// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the data-RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_DW       = 16;
  localparam int DEF_AW       = 13;
  localparam int DEF_MAX_LOCK = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef logic port_idx_t;

  function automatic port_idx_t other_port(input port_idx_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) ();

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          lock0;
  logic          lock1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/ram_arb_grant.sv
// Combinational winner select: locked owner first, otherwise priority port on contention.
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  arb_state_e state,
  input  port_idx_t  owner,
  input  port_idx_t  prio,
  output logic [1:0] gnt,
  output logic       hold
);

  always_comb begin
    gnt  = 2'b00;
    hold = (state == LOCKED) && req[owner] && lock[owner];
    if (hold) begin
      gnt[owner] = 1'b1;
    end else if (&req) begin
      gnt[prio] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a single-port 1-cycle-read RAM with bounded locked bursts.
// Build option RAM_ARB_RR_EN: round-robin priority; otherwise fixed priority to port 0.
//
//   state  | meaning
//   ARB    | no owner; grant by priority each cycle
//   LOCKED | owner holds the RAM while it keeps req&lock, up to MAX_LOCK grants
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [1:0]    req_v;
  logic [1:0]    lock_v;
  logic [1:0]    we_v;
  logic [1:0]    gnt_raw;
  logic [1:0]    gnt;
  logic          hold;
  port_idx_t     win;

  arb_state_e    state_q, state_d;
  port_idx_t     owner_q, owner_d;
  port_idx_t     prio_q, prio_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]    rvalid_q, rvalid_d;

  assign req_v  = {bus.req1, bus.req0};
  assign lock_v = {bus.lock1, bus.lock0};
  assign we_v   = {bus.we1, bus.we0};

  ram_arb_grant u_grant (
    .req   (req_v),
    .lock  (lock_v),
    .state (state_q),
    .owner (owner_q),
    .prio  (prio_q),
    .gnt   (gnt_raw),
    .hold  (hold)
  );

  // Grants are combinational, so they must be forced low directly while reset is asserted.
  assign gnt = rst ? gnt_raw : 2'b00;
  assign win = gnt[1];

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.rvalid0 = rvalid_q[0];
  assign bus.rvalid1 = rvalid_q[1];
  assign bus.rdata   = bus.ram_dout;

  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (gnt[0]) begin
      bus.ram_we   = bus.we0;
      bus.ram_addr = bus.addr0;
      bus.ram_din  = bus.wdata0;
    end else if (gnt[1]) begin
      bus.ram_we   = bus.we1;
      bus.ram_addr = bus.addr1;
      bus.ram_din  = bus.wdata1;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    lock_cnt_d = lock_cnt_q;
    rvalid_d   = gnt & ~we_v;

    if (hold) begin
      // Expiry hands the next slot to the other port even under fixed priority.
      if (lock_cnt_q == CW'(MAX_LOCK - 1)) begin
        state_d    = ARB;
        prio_d     = other_port(owner_q);
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + CW'(1);
      end
    end else begin
      state_d    = ARB;
      lock_cnt_d = '0;
      if (|gnt) begin
`ifdef RAM_ARB_RR_EN
        prio_d = other_port(win);
`else
        prio_d = 1'b0;
`endif
        if (lock_v[win]) begin
          state_d    = LOCKED;
          owner_d    = win;
          lock_cnt_d = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      lock_cnt_q <= '0;
      rvalid_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed arbitration/lock/reset cases plus random traffic
// checked by a read-return scoreboard against a shadow memory.
module tb_ram_arbiter;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int ML = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  ram_arbiter #(.DW(DW), .AW(AW), .MAX_LOCK(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-port RAM model, read-before-write, one cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  // Scoreboard: accepted reads push the shadow-memory value; the return one cycle later pops it.
  typedef struct {
    bit            port;
    bit            known;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e_pop;
  exp_t          e_new;
  logic [DW-1:0] shadow [int];
  logic [29:0]   exp_bus;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) begin
        e_pop = exp_q.pop_front();
        chk("rvalid_port", {30'd0, bus.rvalid1, bus.rvalid0}, e_pop.port ? 32'd2 : 32'd1);
        if (e_pop.known) chk("rdata", {16'd0, bus.rdata}, {16'd0, e_pop.data});
      end else begin
        chk("rvalid_idle", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
      end

      chk("grant_legal", {31'd0, !(bus.gnt0 && bus.gnt1) && (!bus.gnt0 || bus.req0)
                                 && (!bus.gnt1 || bus.req1)}, 32'd1);

      if (bus.gnt0)      exp_bus = {bus.we0, bus.addr0, bus.wdata0};
      else if (bus.gnt1) exp_bus = {bus.we1, bus.addr1, bus.wdata1};
      else               exp_bus = '0;
      chk("ram_bus", {2'd0, bus.ram_we, bus.ram_addr, bus.ram_din}, {2'd0, exp_bus});

      if (bus.gnt0 && bus.req0) begin
        if (bus.we0) shadow[int'(bus.addr0)] = bus.wdata0;
        else begin
          e_new.port  = 1'b0;
          e_new.known = shadow.exists(int'(bus.addr0));
          e_new.data  = e_new.known ? shadow[int'(bus.addr0)] : '0;
          exp_q.push_back(e_new);
        end
      end else if (bus.gnt1 && bus.req1) begin
        if (bus.we1) shadow[int'(bus.addr1)] = bus.wdata1;
        else begin
          e_new.port  = 1'b1;
          e_new.known = shadow.exists(int'(bus.addr1));
          e_new.data  = e_new.known ? shadow[int'(bus.addr1)] : '0;
          exp_q.push_back(e_new);
        end
      end
    end
  end

  task automatic set_port(input bit p, input bit r, input bit we, input bit lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!p) begin
      bus.req0 = r; bus.we0 = we; bus.lock0 = lk; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.lock1 = lk; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic idle_ports();
    set_port(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_ports();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic logic [31:0] gv();
    return {30'd0, bus.gnt1, bus.gnt0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [1:0]    g;
  int            a1;
  bit            pend [2];
  int            wait_cnt [2];
  int            gcount [2];
  logic [31:0]   exp_g;

  initial begin
    // Reset state: request present but reset held
    rst = 1'b0;
    idle_ports();
    set_port(1'b0, 1'b1, 1'b1, 1'b0, 13'h0005, 16'hBEEF);
    @(negedge clk);
    chk("rst_gnt", gv(), 32'd0);
    chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: write then read back through port 0
    @(negedge clk);
    chk("t1_wr_gnt", gv(), 32'd1);
    next_cycle();
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 13'h0005, '0);
    @(negedge clk);
    chk("t1_rd_gnt", gv(), 32'd1);
    next_cycle();
    idle_ports();
    @(negedge clk);
    chk("t1_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd1);
    chk("t1_rdata", {16'd0, bus.rdata}, 32'h0000BEEF);
    next_cycle();

    // 2: simultaneous reads held for three cycles
    do_reset();
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 13'h0100, '0);
    set_port(1'b1, 1'b1, 1'b0, 1'b0, 13'h0101, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
`ifdef RAM_ARB_RR_EN
      exp_g = (i == 1) ? 32'd2 : 32'd1;
`else
      exp_g = 32'd1;
`endif
      chk("t2_gnt", gv(), exp_g);
      next_cycle();
    end
    idle_ports();
    next_cycle();

    // 3: port 1 locked burst over 0x0..0xF with port 0 waiting
    do_reset();
    a1 = 0;
    set_port(1'b1, 1'b1, 1'b0, 1'b1, 13'h0000, '0);
    for (int cyc = 0; cyc < 17; cyc++) begin
      @(negedge clk);
      g = {bus.gnt1, bus.gnt0};
      chk("t3_gnt", gv(), (cyc == ML) ? 32'd1 : 32'd2);
      next_cycle();
      if (cyc == 0) set_port(1'b0, 1'b1, 1'b0, 1'b0, 13'h0020, '0);
      if (g[0]) bus.req0 = 1'b0;
      if (g[1]) begin
        a1++;
        if (a1 == 16) bus.req1 = 1'b0;
        else bus.addr1 = AW'(a1);
      end
    end
    idle_ports();
    next_cycle();

    // 4: write to the same address right after a read must not disturb returned data
    set_port(1'b0, 1'b1, 1'b1, 1'b0, 13'h0010, 16'hAAAA);
    @(negedge clk);
    chk("t4_wr_gnt", gv(), 32'd1);
    next_cycle();
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 13'h0010, '0);
    @(negedge clk);
    chk("t4_rd_gnt", gv(), 32'd1);
    next_cycle();
    set_port(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b1, 1'b1, 1'b0, 13'h0010, 16'h1234);
    @(negedge clk);
    chk("t4_wr1_gnt", gv(), 32'd2);
    chk("t4_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    chk("t4_rdata_old", {16'd0, bus.rdata}, 32'h0000AAAA);
    next_cycle();
    idle_ports();
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 13'h0010, '0);
    next_cycle();
    idle_ports();
    @(negedge clk);
    chk("t4_rdata_new", {16'd0, bus.rdata}, 32'h00001234);
    next_cycle();

    // 5: reset asserted while a read return is pending
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 13'h0005, '0);
    @(negedge clk);
    chk("t5_gnt", gv(), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t5_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("t5_gnt_rst", gv(), 32'd0);
    chk("t5_ram_we", {31'd0, bus.ram_we}, 32'd0);
    next_cycle();
    idle_ports();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    end
    next_cycle();

    // 6: random two-port traffic
    idle_ports();
    g = 2'b00;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; wait_cnt[p] = 0; gcount[p] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && g[p]) pend[p] = 1'b0;
        if (!pend[p]) begin
          if ($urandom_range(0, 1) == 1) begin
            set_port(p[0], 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     AW'($urandom_range(0, 15)), DW'($urandom));
            pend[p] = 1'b1;
            wait_cnt[p] = 0;
          end else begin
            set_port(p[0], 1'b0, 1'b0, 1'b0, '0, '0);
          end
        end
      end
      @(negedge clk);
      g = {bus.gnt1, bus.gnt0};
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          if (g[p]) begin
            gcount[p]++;
            chk("t6_latency", {31'd0, wait_cnt[p] <= 40}, 32'd1);
          end else begin
            wait_cnt[p]++;
          end
        end
      end
      next_cycle();
    end
    for (int p = 0; p < 2; p++) begin
      chk("t6_final_wait", {31'd0, wait_cnt[p] <= 40}, 32'd1);
      chk("t6_port_served", {31'd0, gcount[p] > 0}, 32'd1);
    end
    idle_ports();
    repeat (3) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
